// File: rtl/bht_predictor.sv
// -----------------------------------------------------------------------------
// bht_predictor
//
// Dual-slot branch history table built from 2-bit saturating counters. Both
// fetch slots are looked up every cycle, and the predictions are registered so
// they can travel down the pipe with the instructions. Resolved conditional
// branches from execute train the counters.
//
// Optional feature (compile-time macro BHT_GSHARE_EN):
//   defined     - gshare indexing. The PC index is XORed with the global history
//                 register. pred_ghr carries the GHR snapshot used for the lookup.
//   not defined - pure PC-indexed bimodal table. There is no GHR flop, pred_ghr
//                 is tied to 0, and upd_ghr is ignored.
//
// Parameters:
//   INDEX_W  table index width; the table holds 2^INDEX_W counters.
//            Must be below 30.
//   GHR_W    global history width; must be <= INDEX_W.
//
// Ports:
//   clk, rstn          clock and asynchronous active-low reset
//   fetch_valid        lookup request for this fetch pair
//   stall              hold the registered predictions
//   fetch_pc1/2        slot PCs to look up
//   pred_state1/2      registered predictions (1 = taken)
//   pred_ghr           GHR snapshot used for the registered lookup
//   upd_valid1/2       resolved conditional branch present in the slot
//   upd_kill2          slot 2 squashed by an older redirect
//   upd_pc1/2          resolved branch PCs
//   upd_taken1/2       resolved direction
//   upd_ghr            pred_ghr that travelled with the resolved pair
// -----------------------------------------------------------------------------
module bht_predictor #(
  parameter int INDEX_W = 6,
  parameter int GHR_W   = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fetch_valid,
  input  logic              stall,
  input  logic [31:0]       fetch_pc1,
  input  logic [31:0]       fetch_pc2,
  output logic              pred_state1,
  output logic              pred_state2,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid1,
  input  logic              upd_valid2,
  input  logic              upd_kill2,
  input  logic [31:0]       upd_pc1,
  input  logic [31:0]       upd_pc2,
  input  logic              upd_taken1,
  input  logic              upd_taken2,
  input  logic [GHR_W-1:0]  upd_ghr
);

  localparam int DEPTH = 1 << INDEX_W;

  // Move a 2-bit saturating counter one step toward the resolved direction.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]         cnt_r      [DEPTH];
  logic [1:0]         cnt_slot1_s[DEPTH];
  logic [1:0]         cnt_nxt_s  [DEPTH];
  logic [INDEX_W-1:0] look_idx1_s;
  logic [INDEX_W-1:0] look_idx2_s;
  logic [INDEX_W-1:0] upd_idx1_s;
  logic [INDEX_W-1:0] upd_idx2_s;
  logic               eff1_s;
  logic               eff2_s;

  assign eff1_s = upd_valid1;
  assign eff2_s = upd_valid2 & ~upd_kill2;

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr_r;
  logic [GHR_W-1:0] ghr_step1_s;
  logic [GHR_W-1:0] ghr_nxt_s;
  logic [GHR_W-1:0] pred_ghr_r;

  // Lookups hash with the live GHR; training re-creates the index that was
  // used at prediction time from the carried snapshot.
  always_comb begin
    look_idx1_s = fetch_pc1[INDEX_W+1:2] ^ INDEX_W'(ghr_r);
    look_idx2_s = fetch_pc2[INDEX_W+1:2] ^ INDEX_W'(ghr_r);
    upd_idx1_s  = upd_pc1[INDEX_W+1:2] ^ INDEX_W'(upd_ghr);
    upd_idx2_s  = upd_pc2[INDEX_W+1:2] ^ INDEX_W'(upd_ghr);
  end

  // Shift each effective outcome into the history, slot 1 first.
  always_comb begin
    ghr_step1_s = eff1_s ? GHR_W'({ghr_r, upd_taken1}) : ghr_r;
    ghr_nxt_s   = eff2_s ? GHR_W'({ghr_step1_s, upd_taken2}) : ghr_step1_s;
  end

  // Global history register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr_r <= {GHR_W{1'b0}};
    end else begin
      ghr_r <= ghr_nxt_s;
    end
  end

  // GHR snapshot follows the same load/hold/clear rules as the predictions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_ghr_r <= {GHR_W{1'b0}};
    end else if (stall) begin
      pred_ghr_r <= pred_ghr_r;
    end else if (fetch_valid) begin
      pred_ghr_r <= ghr_r;
    end else begin
      pred_ghr_r <= {GHR_W{1'b0}};
    end
  end

  assign pred_ghr = pred_ghr_r;
`else
  // Bimodal indexing straight from the word-aligned PC bits.
  always_comb begin
    look_idx1_s = fetch_pc1[INDEX_W+1:2];
    look_idx2_s = fetch_pc2[INDEX_W+1:2];
    upd_idx1_s  = upd_pc1[INDEX_W+1:2];
    upd_idx2_s  = upd_pc2[INDEX_W+1:2];
  end

  assign pred_ghr = {GHR_W{1'b0}};
`endif

  // PC bits outside the index field do not take part in the lookup.
  logic unused_ok_s;
`ifdef BHT_GSHARE_EN
  assign unused_ok_s = ^{fetch_pc1[31:INDEX_W+2], fetch_pc1[1:0],
                         fetch_pc2[31:INDEX_W+2], fetch_pc2[1:0],
                         upd_pc1[31:INDEX_W+2], upd_pc1[1:0],
                         upd_pc2[31:INDEX_W+2], upd_pc2[1:0]};
`else
  assign unused_ok_s = ^{fetch_pc1[31:INDEX_W+2], fetch_pc1[1:0],
                         fetch_pc2[31:INDEX_W+2], fetch_pc2[1:0],
                         upd_pc1[31:INDEX_W+2], upd_pc1[1:0],
                         upd_pc2[31:INDEX_W+2], upd_pc2[1:0], upd_ghr};
`endif

  // Next counter values. Slot 2 is applied on top of slot 1's result, so a
  // same-index pair behaves like two back-to-back updates.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cnt_slot1_s[i] = (eff1_s && (upd_idx1_s == INDEX_W'(i)))
                       ? sat_step(cnt_r[i], upd_taken1) : cnt_r[i];
      cnt_nxt_s[i]   = (eff2_s && (upd_idx2_s == INDEX_W'(i)))
                       ? sat_step(cnt_slot1_s[i], upd_taken2) : cnt_slot1_s[i];
    end
  end

  // Counter table; every entry starts weakly not-taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i] <= 2'b01;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Registered predictions. They read the pre-update table (no bypass from
  // training in the same cycle).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_state1 <= 1'b0;
      pred_state2 <= 1'b0;
    end else if (stall) begin
      pred_state1 <= pred_state1;
      pred_state2 <= pred_state2;
    end else if (fetch_valid) begin
      pred_state1 <= cnt_r[look_idx1_s][1];
      pred_state2 <= cnt_r[look_idx2_s][1];
    end else begin
      pred_state1 <= 1'b0;
      pred_state2 <= 1'b0;
    end
  end

endmodule

// File: doc/bht_predictor.md
# bht_predictor

Dual-slot 2-bit saturating-counter branch history table, the prediction source upstream of the branch recovery logic. It looks up both fetch slots each cycle and registers `pred_state1/2`, which travel with the instructions down the pipe as `instr1/2_branch_predict_state`. It consumes resolved outcomes (`taken1/2`, `is_branch1/2`, `flush_signal1`) from execute to train its counters. Optionally it indexes by gshare (PC XOR global history).

## Interface
- `INDEX_W`, default 6: table index width; the table holds 2^INDEX_W entries.
- `GHR_W`, default 6: global history width, must be ≤ INDEX_W; used only when gshare is compiled in.

Ports:
- `clk`  input  1  clock.
- `rstn`  input  1  reset, asynchronous, active-low.
- `fetch_valid`  input  1  lookup request for this fetch pair.
- `stall`  input  1  hold registered predictions.
- `fetch_pc1`, `fetch_pc2`  input  32  slot PCs.
- `pred_state1`, `pred_state2`  output  1  registered prediction, 1 = taken.
- `pred_ghr`  output  GHR_W  GHR snapshot used for this lookup; 0 without gshare.
- `upd_valid1`, `upd_valid2`  input  1  resolved conditional branch in the slot (`is_branch`).
- `upd_kill2`  input  1  slot 2 squashed by an older redirect (`flush_signal1`).
- `upd_pc1`, `upd_pc2`  input  32  branch PCs.
- `upd_taken1`, `upd_taken2`  input  1  resolved direction.
- `upd_ghr`  input  GHR_W  `pred_ghr` carried with the pair; ignored without gshare.

## Operation
- **Table:** 2^INDEX_W 2-bit counters. Prediction = counter[1]. On reset every counter is 2'b01 (weakly not-taken).
- **Index:** `pc[INDEX_W+1:2]`; with gshare, the index is XORed with the zero-extended GHR.
- **Lookup:** when `fetch_valid && !stall`, both slots are read with the current GHR. `pred_state1/2` and `pred_ghr` are registered at the next edge.
  - `fetch_valid=0 && !stall`: the outputs load 0.
  - `stall=1`: the outputs hold, regardless of `fetch_valid`.
- **Training:**
  - Slot 1 is effective when `upd_valid1`. Slot 2 is effective when `upd_valid2 && !upd_kill2`.
  - Taken increments the counter, saturating at 3. Not-taken decrements it, saturating at 0.
- **Same index in both slots:** apply slot 1, then slot 2 to the result. Examples: 01 with T,T gives 11; 11 with N,T gives 11; 00 with T,N gives 00.
- **Jumps:** jumps never train. The caller drives `upd_valid` only for conditional branches.
- **GHR (gshare only):**
  - Shifts left, inserting the outcome of each effective update in slot order. Two effective updates shift by 2.
  - The update index uses `upd_ghr`, not the live GHR.
  - GHR resets to 0.

## Timing
- Lookup latency 1 cycle: PC presented at edge N produces the prediction valid after edge N+1.
- Training writes at the edge ending the update cycle.
- A lookup in that same cycle sees the pre-update counter; there is no bypass.
- Reset asserted mid-operation clears the table, GHR and outputs immediately (asynchronous). Counters return to 01, outputs to 0.
- Reset values of every output: `pred_state1=0`, `pred_state2=0`, `pred_ghr=0`.
- No handshake back-pressure: updates are always accepted.

## Configuration
- **`BHT_GSHARE_EN` defined:** GHR register present; lookup index = PC bits XOR `{0, ghr}`; training index = PC bits XOR `{0, upd_ghr}`; `pred_ghr` = GHR snapshot.
- **Not defined:** no GHR flop; pure PC-indexed bimodal table; `pred_ghr` tied to 0; `upd_ghr` unused.

## Test plan
- **Reset state:** reset, then lookup `fetch_pc1=0x100`, `fetch_pc2=0x104` with `fetch_valid=1` → next cycle `pred_state1=0`, `pred_state2=0`.
- **Training to taken:** train `0x100` taken on two consecutive cycles (`upd_valid1=1`), then look it up → `pred_state1=1`. Train taken twice more → counter stays 11. Train not-taken once → prediction still 1.
- **Same-index pair:** `upd_pc1=upd_pc2=0x200`, both taken, same cycle, from state 01 → counter 11. A following lookup of `0x200` → 1.
- **Kill:** `upd_valid2=1`, `upd_kill2=1`, `upd_taken2=1` on `0x300` three times → lookup of `0x300` still 0.
- **Stall and no-bypass:**
  - Predictions of 1/0 registered, then `stall=1` for 3 cycles while the PCs change → outputs hold 1/0.
  - Lookup and training to the same index in one cycle → the lookup returns the old value.
- **Gshare (`BHT_GSHARE_EN`):**
  - After effective outcomes T then N, GHR = 0b000010 and `pred_ghr` = 2 on the next lookup.
  - Training `0x100` with `upd_ghr=2` does not change the prediction for `0x100` looked up with GHR=0.
